// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for the scratchpad request arbiter
package mem_pkg;

  typedef enum logic {
    M_XRD = 1'b0,
    M_XWR = 1'b1
  } fcn_t;

  typedef enum logic [2:0] {
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_BU = 3'd5,
    MT_HU = 3'd6
  } typ_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    IMEM = 1'b0,
    DMEM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select between imem and dmem
// On contention the port that did not win last time is chosen; a last_grant
// held at IMEM therefore degenerates to fixed dmem priority.
module mem_arb_pick
  import mem_pkg::*;
(
  input  logic   i_valid,
  input  logic   d_valid,
  input  owner_t last_grant,
  output logic   any_valid,
  output owner_t grant
);

  always_comb begin
    any_valid = i_valid | d_valid;
    grant     = IMEM;
    if (i_valid && d_valid) begin
      grant = (last_grant == IMEM) ? DMEM : IMEM;
    end else if (d_valid) begin
      grant = DMEM;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding imem/dmem arbiter for one scratchpad port
// Define MEM_ARB_RR_EN for round-robin on contention; default is fixed dmem priority.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TOW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req_valid,
  output logic          i_req_ready,
  input  logic [AW-1:0] i_req_addr,
  output logic          i_resp_valid,
  output logic [DW-1:0] i_resp_data,
  input  logic          d_req_valid,
  output logic          d_req_ready,
  input  logic [AW-1:0] d_req_addr,
  input  logic [DW-1:0] d_req_data,
  input  logic          d_req_fcn,
  input  logic [2:0]    d_req_typ,
  output logic          d_resp_valid,
  output logic [DW-1:0] d_resp_data,
  output logic          m_req_valid,
  input  logic          m_req_ready,
  output logic [AW-1:0] m_req_addr,
  output logic [DW-1:0] m_req_data,
  output logic          m_req_fcn,
  output logic [2:0]    m_req_typ,
  input  logic          m_resp_valid,
  input  logic [DW-1:0] m_resp_data,
  output logic          err
);

  // Counter value in the WAIT cycle whose increment would reach 2**TOW-1.
  localparam logic [TOW-1:0] CNT_FIRE = {{(TOW-1){1'b1}}, 1'b0};

  arb_state_t     state_q, state_d;
  owner_t         owner_q, owner_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  data_q, data_d;
  logic           fcn_q, fcn_d;
  logic [2:0]     typ_q, typ_d;
  logic [TOW-1:0] cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           any_valid;
  owner_t         grant;
  owner_t         last_grant_q;

  mem_arb_pick u_pick (
    .i_valid    (i_req_valid),
    .d_valid    (d_req_valid),
    .last_grant (last_grant_q),
    .any_valid  (any_valid),
    .grant      (grant)
  );

`ifdef MEM_ARB_RR_EN
  owner_t last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && any_valid) last_grant_d = grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= IMEM;
    else        last_grant_q <= last_grant_d;
  end
`else
  assign last_grant_q = IMEM;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    data_d       = data_q;
    fcn_d        = fcn_q;
    typ_d        = typ_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    i_resp_valid = 1'b0;
    d_resp_valid = 1'b0;
    m_req_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_resp_valid) err_d = 1'b1;
        if (any_valid) begin
          owner_d = grant;
          state_d = ISSUE;
          if (grant == DMEM) begin
            d_req_ready = 1'b1;
            addr_d      = d_req_addr;
            data_d      = d_req_data;
            fcn_d       = d_req_fcn;
            typ_d       = d_req_typ;
          end else begin
            i_req_ready = 1'b1;
            addr_d      = i_req_addr;
            data_d      = '0;
            fcn_d       = M_XRD;
            typ_d       = MT_W;
          end
        end
      end
      ISSUE: begin
        m_req_valid = 1'b1;
        if (m_resp_valid) err_d = 1'b1;
        if (m_req_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (m_resp_valid) begin
          i_resp_valid = (owner_q == IMEM);
          d_resp_valid = (owner_q == DMEM);
          state_d      = IDLE;
        end else if (cnt_q == CNT_FIRE) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= IMEM;
      addr_q  <= '0;
      data_q  <= '0;
      fcn_q   <= 1'b0;
      typ_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      fcn_q   <= fcn_d;
      typ_q   <= typ_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign m_req_addr  = addr_q;
  assign m_req_data  = data_q;
  assign m_req_fcn   = fcn_q;
  assign m_req_typ   = typ_q;
  assign i_resp_data = m_resp_data;
  assign d_resp_data = m_resp_data;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed plus randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready, i_resp_valid;
  logic [31:0] i_req_addr, i_resp_data;
  logic        d_req_valid, d_req_ready, d_resp_valid, d_req_fcn;
  logic [31:0] d_req_addr, d_req_data, d_resp_data;
  logic [2:0]  d_req_typ;
  logic        m_req_valid, m_req_ready, m_req_fcn, m_resp_valid, err;
  logic [31:0] m_req_addr, m_req_data, m_resp_data;
  logic [2:0]  m_req_typ;

  int total = 0;
  int bad   = 0;
  bit last_was_d = 1'b0;
  bit err_exp    = 1'b0;
  logic [2:0] typs [5];

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .TOW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_data(d_req_data), .d_req_fcn(d_req_fcn), .d_req_typ(d_req_typ),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_data(m_req_data), .m_req_fcn(m_req_fcn), .m_req_typ(m_req_typ),
    .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic new_d_req();
    d_req_valid = 1'b1;
    d_req_addr  = $urandom;
    d_req_data  = $urandom;
    d_req_fcn   = 1'($urandom_range(0, 1));
    d_req_typ   = typs[$urandom_range(0, 4)];
  endtask

  task automatic new_i_req();
    i_req_valid = 1'b1;
    i_req_addr  = $urandom;
  endtask

  // Reference rule: with both pending, round-robin grants the port that did
  // not win last; fixed mode always prefers dmem.
  function automatic bit predict_d();
`ifdef MEM_ARB_RR_EN
    if (i_req_valid && d_req_valid) return !last_was_d;
`endif
    return d_req_valid;
  endfunction

  // One complete transaction starting in IDLE, just after a clock edge.
  task automatic txn(input int stall, input int lat, input logic [31:0] rdata, output bit won_d);
    logic [31:0] ea, ed;
    logic        ef;
    logic [2:0]  et;
    won_d = predict_d();
    @(negedge clk);
    chk("idle_i_ready", i_req_ready, !won_d);
    chk("idle_d_ready", d_req_ready, won_d);
    chk("idle_m_valid", m_req_valid, 1'b0);
    ea = won_d ? d_req_addr : i_req_addr;
    ed = won_d ? d_req_data : 32'h0;
    ef = won_d ? d_req_fcn  : 1'b0;
    et = won_d ? d_req_typ  : 3'(MT_W);
    last_was_d = won_d;
    after_edge();
    if (won_d) begin
      d_req_valid = 1'b0; d_req_addr = $urandom; d_req_data = $urandom;
    end else begin
      i_req_valid = 1'b0; i_req_addr = $urandom;
    end
    for (int s = 0; s <= stall; s++) begin
      m_req_ready = (s == stall);
      @(negedge clk);
      chk("issue_valid", m_req_valid, 1'b1);
      chk("issue_addr", m_req_addr, ea);
      chk("issue_data", m_req_data, ed);
      chk("issue_fcn", m_req_fcn, ef);
      chk("issue_typ", m_req_typ, et);
      chk("issue_rdy", {i_req_ready, d_req_ready}, 2'b00);
      after_edge();
    end
    m_req_ready = 1'b0;
    for (int w = 0; w < lat; w++) begin
      @(negedge clk);
      chk("wait_quiet", {m_req_valid, i_resp_valid, d_resp_valid, i_req_ready, d_req_ready}, 5'b0);
      after_edge();
    end
    m_resp_valid = 1'b1;
    m_resp_data  = rdata;
    @(negedge clk);
    chk("resp_i_valid", i_resp_valid, !won_d);
    chk("resp_d_valid", d_resp_valid, won_d);
    chk("resp_i_data", i_resp_data, rdata);
    chk("resp_d_data", d_resp_data, rdata);
    chk("resp_err", err, err_exp);
    after_edge();
    m_resp_valid = 1'b0;
    m_resp_data  = $urandom;
  endtask

  initial begin
    bit won;
    typs = '{MT_B, MT_H, MT_W, MT_BU, MT_HU};
    rst_n = 1'b0;
    i_req_valid = 0; i_req_addr = 0;
    d_req_valid = 0; d_req_addr = 0; d_req_data = 0; d_req_fcn = 0; d_req_typ = 0;
    m_req_ready = 0; m_resp_valid = 0; m_resp_data = 0;
    #12;
    chk("rst_outs", {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, m_req_valid, err}, 6'b0);
    chk("rst_mreq", {m_req_addr, m_req_data}, 64'h0);
    chk("rst_mfields", {m_req_fcn, m_req_typ}, 4'h0);
    rst_n = 1'b1;
    after_edge();

    // imem-only read, minimum latency
    i_req_valid = 1'b1; i_req_addr = 32'h40;
    txn(0, 0, 32'h1234_5678, won);
    chk("t1_grant", won, 1'b0);

    // contention: dmem write first, then the held imem request
    i_req_valid = 1'b1; i_req_addr = 32'h44;
    d_req_valid = 1'b1; d_req_addr = 32'h80; d_req_data = 32'hDEAD_BEEF;
    d_req_fcn = 1'b1; d_req_typ = MT_W;
    txn(0, 1, 32'h0, won);
    chk("t2_grant_d", won, 1'b1);
    txn(1, 0, 32'hCAFE_0001, won);
    chk("t2_grant_i", won, 1'b0);

`ifdef MEM_ARB_RR_EN
    new_i_req();
    new_d_req();
    for (int k = 0; k < 4; k++) begin
      txn($urandom_range(0, 1), $urandom_range(0, 2), $urandom, won);
      chk("rr_alternate", won, (k % 2 == 0));
      if (k < 3) begin
        if (won) new_d_req();
        else     new_i_req();
      end
    end
`endif

    // long issue stall with both requesters waiting
    if (!i_req_valid) new_i_req();
    if (!d_req_valid) new_d_req();
    txn(5, 2, $urandom, won);

    for (int n = 0; n < 16; n++) begin
      if (!i_req_valid && $urandom_range(0, 1) == 1) new_i_req();
      if (!d_req_valid && $urandom_range(0, 1) == 1) new_d_req();
      if (!i_req_valid && !d_req_valid) new_i_req();
      txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom, won);
    end
    while (i_req_valid || d_req_valid) txn(0, 0, $urandom, won);

    // spurious response in IDLE
    m_resp_valid = 1'b1; m_resp_data = $urandom;
    @(negedge clk);
    chk("spur_no_resp", {i_resp_valid, d_resp_valid}, 2'b00);
    after_edge();
    m_resp_valid = 1'b0;
    err_exp = 1'b1;
    @(negedge clk);
    chk("spur_err", err, 1'b1);
    after_edge();
    new_d_req();
    txn(0, 1, $urandom, won);
    chk("spur_err_sticky", err, 1'b1);

    rst_n = 1'b0;
    #1;
    chk("rst_clears_err", err, 1'b0);
    err_exp = 1'b0;
    last_was_d = 1'b0;
    after_edge();
    rst_n = 1'b1;
    after_edge();

    // response timeout, TOW=3 fires on the 7th WAIT cycle
    i_req_valid = 1'b1; i_req_addr = $urandom;
    @(negedge clk);
    chk("to_accept", i_req_ready, 1'b1);
    after_edge();
    i_req_valid = 1'b0; m_req_ready = 1'b1;
    @(negedge clk);
    chk("to_issue", m_req_valid, 1'b1);
    after_edge();
    m_req_ready = 1'b0;
    for (int w = 1; w <= 7; w++) begin
      @(negedge clk);
      chk("to_wait_err", err, 1'b0);
      chk("to_wait_quiet", {m_req_valid, i_resp_valid, d_resp_valid}, 3'b0);
      after_edge();
    end
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    @(negedge clk);
    chk("to_err_set", err, 1'b1);
    chk("to_back_idle", i_req_ready, 1'b1);
    after_edge();
    i_req_valid = 1'b0; m_req_ready = 1'b1;
    after_edge();
    m_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_err", err, 1'b0);
    chk("async_rst_valids", {m_req_valid, i_resp_valid, d_resp_valid, i_req_ready, d_req_ready}, 5'b0);
    chk("async_rst_addr", m_req_addr, 32'h0);
    after_edge();
    rst_n = 1'b1;
    after_edge();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
